// File: rtl/mem_arb_pkg.sv
// Shared types and the round-robin pick function for the memory-port arbiter.
package mem_arb_pkg;

  localparam int MAX_MASTERS = 16;
  localparam int MAX_ID_W    = 4;

  typedef enum logic {
    ARB_S  = 1'b0,
    HOLD_S = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                found;
    logic [MAX_ID_W-1:0] id;
  } rr_pick_t;

  // First requester at or after ptr, wrapping modulo num (ptr must be < num).
  function automatic rr_pick_t rr_pick(input logic [MAX_MASTERS-1:0] req,
                                       input logic [MAX_ID_W-1:0]    ptr,
                                       input int unsigned            num);
    rr_pick_t    res;
    int unsigned idx;
    res = '0;
    for (int unsigned k = 0; k < MAX_MASTERS; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= num) idx = idx - num;
      if (!res.found && (k < num) && req[idx[MAX_ID_W-1:0]]) begin
        res.found = 1'b1;
        res.id    = idx[MAX_ID_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_arbiter_id_fifo.sv
// Master-ID FIFO: remembers who issued each outstanding request, in issue order.
module id_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid memory port between several masters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_MASTERS   = 2,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ID_FIFO_DEPTH = 2,
  localparam int ID_W  = $clog2(NUM_MASTERS),
  localparam int CNT_W = $clog2(ID_FIFO_DEPTH + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_MASTERS-1:0]                 m_req_i,
  output logic [NUM_MASTERS-1:0]                 m_gnt_o,
  output logic [NUM_MASTERS-1:0]                 m_rvalid_o,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS-1:0]                 m_we_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_wdata_i,
  output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_rdata_o,
  output logic                                   s_req_o,
  input  logic                                   s_gnt_i,
  input  logic                                   s_rvalid_i,
  output logic [ADDR_WIDTH-1:0]                  s_addr_o,
  output logic                                   s_we_o,
  output logic [DATA_WIDTH-1:0]                  s_wdata_o,
  input  logic [DATA_WIDTH-1:0]                  s_rdata_i,
  output logic [CNT_W-1:0]                       outstanding_o,
  output logic                                   err_o,
  output arb_state_e                             dbg_state_o
);

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] lock_id_q, lock_id_d, rr_ptr_q, rr_ptr_d;
  logic            err_q, err_d;
  logic [ID_W-1:0] sel_id, head_id;
  logic            sel_valid, stall, hs, pop;
  logic            fifo_full, fifo_empty;
  rr_pick_t        pick;

  id_fifo #(.WIDTH(ID_W), .DEPTH(ID_FIFO_DEPTH)) u_id_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (hs),
    .data_i  (sel_id),
    .pop_i   (s_rvalid_i),
    .data_o  (head_id),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding_o)
  );

  assign pick        = rr_pick(MAX_MASTERS'(m_req_i), MAX_ID_W'(rr_ptr_q), 32'(NUM_MASTERS));
  // A response frees a FIFO slot in the same cycle, so a full FIFO only stalls without one.
  assign stall       = fifo_full & ~s_rvalid_i;
  assign pop         = s_rvalid_i & ~fifo_empty;
  assign err_o       = err_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_S;
      lock_id_q <= '0;
      rr_ptr_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      rr_ptr_q  <= rr_ptr_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    rr_ptr_d  = rr_ptr_q;
    err_d     = err_q | (s_rvalid_i & fifo_empty);
    if (hs) rr_ptr_d = (sel_id == ID_W'(NUM_MASTERS - 1)) ? '0 : sel_id + 1'b1;
    case (state_q)
      ARB_S: if (s_req_o && !s_gnt_i) begin
        state_d   = HOLD_S;
        lock_id_d = sel_id;
      end
      // Leaves on handshake, or when the locked master abandons its request.
      HOLD_S: if (hs || !m_req_i[lock_id_q]) state_d = ARB_S;
      default: state_d = ARB_S;
    endcase
  end

  always_comb begin
    sel_id     = '0;
    sel_valid  = 1'b0;
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    if (state_q == HOLD_S) begin
      sel_id    = lock_id_q;
      sel_valid = m_req_i[lock_id_q];
    end else begin
      sel_id    = pick.id[ID_W-1:0];
      sel_valid = pick.found;
    end
    s_req_o   = sel_valid & ~stall;
    hs        = s_req_o & s_gnt_i;
    s_addr_o  = s_req_o ? m_addr_i[sel_id]  : '0;
    s_we_o    = s_req_o ? m_we_i[sel_id]    : 1'b0;
    s_wdata_o = s_req_o ? m_wdata_i[sel_id] : '0;
    if (hs)  m_gnt_o[sel_id]     = 1'b1;
    if (pop) m_rvalid_o[head_id] = 1'b1;
    for (int i = 0; i < NUM_MASTERS; i++) m_rdata_o[i] = s_rdata_i;
  end

endmodule
